// File: rtl/gol_pkg.sv
// ============================================================================
// Module  : gol_pkg
// Brief   : Shared constants and state type for the Game of Life board store.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package gol_pkg;

  localparam int c_BOARD_W       = 64;
  localparam int c_BOARD_H       = 32;
  localparam int ADDR_W          = 11;
  localparam int CLOCK_FREQ      = 24_000_000;
  localparam int UPDATE_INTERVAL = CLOCK_FREQ / 10;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] c_LFSR_SEED = 16'h0001;
  localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INIT   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_SWAP   = 2'd3
  } gol_state_e;

endpackage

`default_nettype wire

// File: rtl/gol_mem_scheduler_if.sv
// ============================================================================
// Module  : gol_mem_scheduler_if
// Brief   : Display, engine and RAM port signals shared with the scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface gol_mem_scheduler_if #(
  parameter int ADDR_W = gol_pkg::ADDR_W
) ();

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;

  logic              eng_req;
  logic              eng_we;
  logic              eng_wdata;
  logic [ADDR_W-1:0] eng_addr;
  logic              eng_gnt;
  logic              eng_rvalid;
  logic              step_start;
  logic              step_done;

  logic              mem_en;
  logic              mem_we;
  logic              mem_bank;
  logic              mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rdata;

  modport slave (
    input  disp_req, disp_addr, eng_req, eng_we, eng_wdata, eng_addr,
           step_done, mem_rdata,
    output disp_gnt, disp_rvalid, eng_gnt, eng_rvalid, step_start,
           mem_en, mem_we, mem_bank, mem_wdata, mem_addr
  );

  modport master (
    output disp_req, disp_addr, eng_req, eng_we, eng_wdata, eng_addr,
           step_done, mem_rdata,
    input  disp_gnt, disp_rvalid, eng_gnt, eng_rvalid, step_start,
           mem_en, mem_we, mem_bank, mem_wdata, mem_addr
  );

endinterface

`default_nettype wire

// File: rtl/gol_lfsr16.sv
// ============================================================================
// Module  : gol_lfsr16
// Brief   : Free-running 16-bit Fibonacci LFSR, reseeded on reset.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gol_lfsr16
  import gol_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] rng
);

  logic [15:0] r_state;
  logic        w_fb;

  assign w_fb = ^(r_state & c_LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_LFSR_SEED;
    end else begin
      r_state <= {r_state[14:0], w_fb};
    end
  end

  assign rng = r_state;

endmodule

`default_nettype wire

// File: rtl/gol_mem_scheduler.sv
// ============================================================================
// Module  : gol_mem_scheduler
// Brief   : Generation sequencer and single-port board RAM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gol_mem_scheduler
  import gol_pkg::*;
#(
  parameter int ADDR_W          = gol_pkg::ADDR_W,
  parameter int UPDATE_INTERVAL = gol_pkg::UPDATE_INTERVAL
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                randomize,
  input  logic                vsync,
  gol_mem_scheduler_if.slave  bus,
  output logic                front,
  output logic                busy,
  output logic [15:0]         gen_count
);

  localparam logic [1:0] c_ST_IDLE   = ST_IDLE;
  localparam logic [1:0] c_ST_INIT   = ST_INIT;
  localparam logic [1:0] c_ST_UPDATE = ST_UPDATE;
  localparam logic [1:0] c_ST_SWAP   = ST_SWAP;

  localparam int                 c_TMR_W   = $clog2(UPDATE_INTERVAL + 1);
  localparam logic [c_TMR_W-1:0] c_TMR_MAX = c_TMR_W'(UPDATE_INTERVAL);

  logic [1:0]         r_state;
  logic [c_TMR_W-1:0] r_timer;
  logic [ADDR_W-1:0]  r_fill_addr;
  logic               r_front;
  logic [15:0]        r_gen_count;
  logic               r_disp_rvalid;
  logic               r_eng_rvalid;
  logic               r_step_start;

  logic [15:0]        w_rng;
  logic               w_disp_gnt;
  logic               w_fill_gnt;
  logic               w_eng_gnt;
  logic               w_unused;

  gol_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .rng   (w_rng)
  );

  // Display always wins; fill and engine only see cycles the display leaves free.
  assign w_disp_gnt = bus.disp_req;
  assign w_fill_gnt = (r_state == c_ST_INIT) && !bus.disp_req;
  assign w_eng_gnt  = (r_state == c_ST_UPDATE) && !bus.disp_req && bus.eng_req;

  always_comb begin
    bus.mem_bank  = r_front;
    bus.mem_addr  = '0;
    bus.mem_wdata = 1'b0;
    if (w_disp_gnt) begin
      bus.mem_addr = bus.disp_addr;
    end else if (w_fill_gnt) begin
      bus.mem_addr  = r_fill_addr;
      bus.mem_wdata = w_rng[0];
    end else if (w_eng_gnt) begin
      bus.mem_addr  = bus.eng_addr;
      bus.mem_wdata = bus.eng_wdata;
      bus.mem_bank  = bus.eng_we ? ~r_front : r_front;
    end
  end

  assign bus.mem_en      = w_disp_gnt | w_fill_gnt | w_eng_gnt;
  assign bus.mem_we      = w_fill_gnt | (w_eng_gnt & bus.eng_we);
  assign bus.disp_gnt    = w_disp_gnt;
  assign bus.eng_gnt     = w_eng_gnt;
  assign bus.disp_rvalid = r_disp_rvalid;
  assign bus.eng_rvalid  = r_eng_rvalid;
  assign bus.step_start  = r_step_start;

  // Read data is consumed by the requesters directly, not by the scheduler.
  assign w_unused = ^{bus.mem_rdata, w_rng[15:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= c_ST_INIT;
      r_timer       <= '0;
      r_fill_addr   <= '0;
      r_front       <= 1'b0;
      r_gen_count   <= '0;
      r_disp_rvalid <= 1'b0;
      r_eng_rvalid  <= 1'b0;
      r_step_start  <= 1'b0;
    end else begin
      r_disp_rvalid <= w_disp_gnt;
      r_eng_rvalid  <= w_eng_gnt & ~bus.eng_we;
      r_step_start  <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (run) begin
            if (r_timer < c_TMR_MAX) begin
              r_timer <= r_timer + 1'b1;
            end else if (vsync) begin
              r_timer <= '0;
              if (randomize) begin
                r_state <= c_ST_INIT;
              end else begin
                r_state      <= c_ST_UPDATE;
                r_step_start <= 1'b1;
              end
            end
          end
        end
        c_ST_INIT: begin
          if (w_fill_gnt) begin
            if (&r_fill_addr) begin
              r_fill_addr <= '0;
              r_gen_count <= '0;
              r_state     <= c_ST_IDLE;
            end else begin
              r_fill_addr <= r_fill_addr + 1'b1;
            end
          end
        end
        c_ST_UPDATE: begin
          if (bus.step_done) begin
            r_state <= c_ST_SWAP;
          end
        end
        c_ST_SWAP: begin
          r_front     <= ~r_front;
          r_gen_count <= r_gen_count + 16'd1;
          r_state     <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign front     = r_front;
  assign busy      = (r_state != c_ST_IDLE);
  assign gen_count = r_gen_count;

endmodule

`default_nettype wire

// File: doc/gol_mem_scheduler.md
# gol_mem_scheduler

Sequencer and memory-port arbiter for the Game of Life board store. It owns one single-port, 1-bit-wide board RAM split into two banks (front and back) and grants its port each cycle to one of three requesters: VGA scanout (display), the board randomizer (internal), or the external next-state update engine. It sequences generations (INIT, UPDATE, SWAP) on the 10 Hz interval timer. Bank ping-pong replaces the copy pass.

## Interface
Parameters:
- `ADDR_W`, 11: board address width (64x32 cells; address = {y[4:0], x[5:0]}).
- `UPDATE_INTERVAL`, 2400000: idle clocks between generations (24 MHz / 10).

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `run`  in  1: 1 = simulation advances; 0 = interval timer frozen.
- `randomize`  in  1: sampled at launch; 1 = reseed the board instead of stepping.
- `vsync`  in  1: launch qualifier.
- `disp_req`, `disp_addr[ADDR_W-1:0]`  in: display read request.
- `disp_gnt`  out  1: combinational grant.
- `disp_rvalid`  out  1: `mem_rdata` is the display's data this cycle.
- `eng_req`, `eng_we`, `eng_wdata`  in  1 each; `eng_addr[ADDR_W-1:0]`  in: engine access.
- `eng_gnt`  out  1: combinational grant.
- `eng_rvalid`  out  1: `mem_rdata` is the engine's read data this cycle.
- `step_start`  out  1: one-cycle pulse that starts the engine.
- `step_done`  in  1: one-cycle pulse from the engine.
- `mem_en`, `mem_we`, `mem_bank`, `mem_wdata`  out  1 each; `mem_addr[ADDR_W-1:0]`  out: RAM port, combinational.
- `mem_rdata`  in  1: RAM read data, 1-cycle latency.
- `front`  out  1: bank currently displayed.
- `busy`  out  1: state is not IDLE.
- `gen_count[15:0]`  out: generations since the last INIT.

## Operation
- States:
  - IDLE
  - INIT
  - UPDATE
  - SWAP
- Reset values:
  - state = INIT, so reset triggers a boot randomize.
  - `front` = 0, `gen_count` = 0, timer = 0, fill address = 0, `lfsr` = 16'h0001.
  - Both rvalid outputs = 0; `step_start` = 0.
- IDLE:
  - If `run` = 1 and timer < `UPDATE_INTERVAL`, the timer increments.
  - If `run` = 1, timer ≥ `UPDATE_INTERVAL` and `vsync` = 1, the block launches: timer ← 0, next state = INIT if `randomize`, else UPDATE.
- INIT:
  - Writes `lfsr[0]` to `front` bank at the fill address, on fill-granted cycles only.
  - The fill address increments after each such write.
  - After the write to address 2^ADDR_W−1: fill address ← 0, `gen_count` ← 0, state → IDLE.
- UPDATE:
  - `step_start` pulses in the first cycle of the state.
  - The engine reads from `front` and writes to the back bank through the arbiter.
  - `step_done` → SWAP.
- SWAP (one cycle): `front` ← ~`front`, `gen_count` += 1 (wraps at 16 bits), state → IDLE.
- Arbitration, at most one grant per cycle. Priority order:
  1. display
  2. INIT fill
  3. engine
- Engine grant conditions: only in UPDATE, with `disp_req` = 0.
- Display reads always target `front`.
- Bank selection for engine accesses:
  - Reads: `mem_bank` = `front`.
  - Writes: `mem_bank` = ~`front`.
- `mem_en` = any grant; `mem_we` = fill grant or (engine grant and `eng_we`).
- A requester holds `req`, address and data stable until it is granted. A losing engine request simply waits.
- The LFSR is a 16-bit Fibonacci LFSR with taps 16, 14, 13, 11. It shifts left every cycle, free-running, and inserts the feedback bit at bit 0.

## Timing
- Grants are same-cycle and combinational.
- `disp_rvalid` / `eng_rvalid` are registered and assert exactly 1 cycle after a granted read (`we` = 0).
- INIT length: 2^ADDR_W cycles plus one cycle for every display grant during the fill.
- Latency from launch to `step_start`: 1 cycle after the launch edge.
- SWAP follows `step_done` by 1 cycle; `front` toggles at the end of that cycle.
- Boundary conditions:
  - `step_done` outside UPDATE: ignored.
  - `eng_req` outside UPDATE: never granted.
  - `run` falling mid-UPDATE: the step and swap complete; the timer then freezes in IDLE.
  - `randomize`: affects only launch decisions.
  - Reset mid-operation: the next cycle re-enters INIT at fill address 0 with `front` = 0. Pending rvalids clear.

## Structure
- Shared package `gol_pkg`:
  - State enum (IDLE/INIT/UPDATE/SWAP).
  - `ADDR_W`, board dimensions.
  - `CLOCK_FREQ`, `UPDATE_INTERVAL`.
  - LFSR seed and tap constants.
- Sub-module `gol_lfsr16`: 16-bit LFSR with a synchronous seed load on reset and `rng` output. The arbiter and FSM stay in this module.

## Test plan
- Release reset with `disp_req` = 0:
  - INIT writes bank 0, addresses 0..2047, on 2048 consecutive cycles.
  - First `mem_wdata` = 1 (seed LSB).
  - Then `busy` = 0 and `gen_count` = 0.
- INIT with `disp_req` pulsed every 8th cycle:
  - Fill pauses on those cycles and takes 2048 + pulses cycles.
  - No address is skipped or repeated.
- In UPDATE with `disp_req` = `eng_req` = 1 (read, `eng_addr` = 0x123):
  - `disp_gnt` = 1, `eng_gnt` = 0, `mem_bank` = `front`.
  - Next cycle: `disp_gnt` = 0, `eng_gnt` = 1; the following cycle `eng_rvalid` = 1.
- Engine write with `eng_we` = 1, addr 0x7FF, data 1, `front` = 0 → `mem_we` = 1, `mem_bank` = 1, `mem_addr` = 0x7FF.
- Launch and swap with `UPDATE_INTERVAL` = 10, `run` = 1:
  - With `vsync` = 0, no launch.
  - When `vsync` rises after the timer reaches 10: `step_start` pulses once.
  - `step_done` → `front` 0→1 and `gen_count` = 1 two cycles later.
- `randomize` = 1 at launch → INIT, `gen_count` returns to 0, `front` unchanged.
- `rst_n` low for 1 cycle mid-UPDATE → `front` = 0 and fill restarts at address 0.
